// File: rtl/inv_sbox_iter.sv
// -----------------------------------------------------------------------------
// inv_sbox_iter
// Multi-cycle AES inverse S-box (InvSubBytes) for one byte on the decryption
// datapath. The byte is inverse-affine transformed, mapped into the composite
// field GF((2^4)^2), inverted using GF(2^4) primitives and mapped back to GF(2^8).
// One transaction in flight, valid/ready handshake on both sides.
//
// Parameters
//   REG_ISO   1 = extra register stage after the isomorphism (adds 1 cycle)
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_byte valid
//   in_ready   out  block can accept a byte (state == IDLE)
//   in_byte    in   ciphertext-side byte, AES polynomial basis
//   out_valid  out  out_byte valid
//   out_ready  in   consumer accepts out_byte
//   out_byte   out  InvSubBytes(in_byte), held until the next MIX
//   busy       out  state != IDLE
// -----------------------------------------------------------------------------
module inv_sbox_iter #(
    parameter bit REG_ISO = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       busy
);

    // Composite field: GF(2^4) = GF(2)[x]/(x^4+x+1),
    // GF((2^4)^2) = GF(2^4)[y]/(y^2+y+LAMBDA). Element {h,l} = h*y + l.
    localparam logic [3:0] LAMBDA = 4'hC;

    function automatic logic [3:0] mul4(input logic [3:0] a, input logic [3:0] b);
        logic [6:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p ^= 7'(a) << i;
        for (int i = 6; i >= 4; i--)
            if (p[i]) p ^= 7'b0010011 << (i - 4);
        return p[3:0];
    endfunction

    function automatic logic [3:0] sq4(input logic [3:0] a);
        return mul4(a, a);
    endfunction

    // a^14 == a^-1 for nonzero a; 0 maps to 0.
    function automatic logic [3:0] inv4(input logic [3:0] a);
        logic [3:0] a2, a4, a8;
        a2 = sq4(a);
        a4 = sq4(a2);
        a8 = sq4(a4);
        return mul4(mul4(a8, a4), a2);
    endfunction

    // Full composite-field multiply; only used to derive the isomorphism.
    function automatic logic [7:0] mul8c(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] hh, hi, lo;
        hh = mul4(a[7:4], b[7:4]);
        hi = hh ^ mul4(a[7:4], b[3:0]) ^ mul4(a[3:0], b[7:4]);
        lo = mul4(hh, LAMBDA) ^ mul4(a[3:0], b[3:0]);
        return {hi, lo};
    endfunction

    // Apply an 8x8 GF(2) matrix stored as 8 packed columns (column i = image of bit i).
    function automatic logic [7:0] lin8(input logic [63:0] m, input logic [7:0] x);
        logic [7:0] y;
        y = '0;
        for (int i = 0; i < 8; i++)
            if (x[i]) y ^= m[i*8 +: 8];
        return y;
    endfunction

    // delta maps alpha^i to beta^i, where beta is the first composite-field root
    // of the AES polynomial x^8+x^4+x^3+x+1. Derived at elaboration from the
    // shared field definition so the forward and inverse S-box agree by construction.
    function automatic logic [63:0] build_delta();
        logic [63:0] cols, tmp;
        logic [7:0]  pw, acc, b;
        bit          found;
        cols  = '0;
        tmp   = '0;
        found = 1'b0;
        for (int c = 2; c < 256; c++) begin
            b   = 8'(c);
            pw  = 8'h01;
            acc = 8'h01;
            tmp[7:0] = pw;
            for (int i = 1; i <= 8; i++) begin
                pw = mul8c(pw, b);
                if (i < 8) tmp[i*8 +: 8] = pw;
                if (i == 1 || i == 3 || i == 4 || i == 8) acc ^= pw;
            end
            if (!found && acc == 8'h00) begin
                found = 1'b1;
                cols  = tmp;
            end
        end
        return cols;
    endfunction

    function automatic logic [63:0] build_delta_inv(input logic [63:0] m);
        logic [63:0] inv;
        logic [7:0]  y;
        inv = '0;
        for (int x = 0; x < 256; x++) begin
            y = lin8(m, 8'(x));
            for (int j = 0; j < 8; j++)
                if (y == 8'(1 << j)) inv[j*8 +: 8] = 8'(x);
        end
        return inv;
    endfunction

    localparam logic [63:0] DELTA     = build_delta();
    localparam logic [63:0] DELTA_INV = build_delta_inv(DELTA);

    // AES inverse affine: rotl1 ^ rotl3 ^ rotl6 ^ 8'h05.
    function automatic logic [7:0] inv_affine(input logic [7:0] x);
        return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    endfunction

    typedef enum logic [2:0] {IDLE, ISO, ISO2, INV, MIX, HOLD} state_t;

    state_t     state_q, state_d;
    logic [7:0] byte_q, byte_d;
    logic [7:0] iso_q, iso_d;
    logic [7:0] iso2_q, iso2_d;
    logic [3:0] di_q, di_d;
    logic [7:0] out_byte_q, out_byte_d;
    logic       out_valid_q, out_valid_d;

    logic [7:0] iso_calc, mix_calc;
    logic [3:0] ah, al, norm;

    assign iso_calc = lin8(DELTA, inv_affine(byte_q));
    assign {ah, al} = REG_ISO ? iso2_q : iso_q;
    // Norm of ah*y+al: ah^2*LAMBDA + ah*al + al^2; inverse = (ah*d^-1)y + (ah^al)*d^-1.
    assign norm     = mul4(sq4(ah), LAMBDA) ^ mul4(ah, al) ^ sq4(al);
    assign mix_calc = lin8(DELTA_INV, {mul4(ah, di_q), mul4(ah ^ al, di_q)});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_q      <= '0;
            iso_q       <= '0;
            iso2_q      <= '0;
            di_q        <= '0;
            out_byte_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_q      <= byte_d;
            iso_q       <= iso_d;
            iso2_q      <= iso2_d;
            di_q        <= di_d;
            out_byte_q  <= out_byte_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        iso_d       = iso_q;
        iso2_d      = iso2_q;
        di_d        = di_q;
        out_byte_d  = out_byte_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    byte_d  = in_byte;
                    state_d = ISO;
                end
            end
            ISO: begin
                iso_d   = iso_calc;
                state_d = REG_ISO ? ISO2 : INV;
            end
            ISO2: begin
                iso2_d  = iso_q;
                state_d = INV;
            end
            INV: begin
                di_d    = inv4(norm);
                state_d = MIX;
            end
            MIX: begin
                out_byte_d  = mix_calc;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                // in_ready stays low this cycle, so no accept can coincide with the handshake.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_byte  = out_byte_q;

endmodule

// File: tb/tb_inv_sbox_iter.sv
module tb_inv_sbox_iter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid  [2];
    logic       in_ready  [2];
    logic [7:0] in_byte   [2];
    logic       out_valid [2];
    logic       out_ready [2];
    logic [7:0] out_byte  [2];
    logic       busy      [2];

    int checks = 0;
    int failures = 0;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    always #5 clk = ~clk;

    inv_sbox_iter #(.REG_ISO(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_byte(in_byte[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_byte(out_byte[0]),
        .busy(busy[0])
    );

    inv_sbox_iter #(.REG_ISO(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_byte(in_byte[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_byte(out_byte[1]),
        .busy(busy[1])
    );

    // Reference: plain GF(2^8) arithmetic modulo the AES polynomial.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h00;
        for (int c = 1; c < 256; c++)
            if (gmul(a, 8'(c)) == 8'h01) r = 8'(c);
        return r;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] b;
        b = ginv(x);
        return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transaction with out_ready held high. Returns the output byte, cycles
    // from the accept edge to out_valid, and how many cycles in_ready stayed low.
    task automatic txn(input int d, input logic [7:0] b,
                       output logic [7:0] res, output int lat, output int lowcnt);
        int n;
        bit got;
        n = 0;
        @(negedge clk);
        while (!in_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        in_valid[d]  = 1'b1;
        in_byte[d]   = b;
        out_ready[d] = 1'b1;
        @(posedge clk);
        #1 in_valid[d] = 1'b0;
        @(negedge clk);
        lowcnt = in_ready[d] ? 0 : 1;
        got = 1'b0;
        lat = -1;
        res = 8'h00;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[d] && !got) begin
                got = 1'b1;
                lat = k;
                res = out_byte[d];
            end
            if (in_ready[d]) break;
            lowcnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] res, x;
        int lat, lowcnt, n;
        logic [7:0] dir_in  [4];
        logic [7:0] dir_out [4];

        for (int i = 0; i < 256; i++) begin
            fwd_tab[i] = sbox(8'(i));
            inv_tab[fwd_tab[i]] = 8'(i);
        end
        dir_in  = '{8'h7C, 8'h00, 8'hED, 8'h16};
        dir_out = '{8'h01, 8'h52, 8'h53, 8'hFF};

        for (int d = 0; d < 2; d++) begin
            in_valid[d] = 1'b0; in_byte[d] = 8'h00; out_ready[d] = 1'b1;
        end

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
        chk("rst_out_byte",  32'(out_byte[0]),  32'h00);
        chk("rst_busy",      32'(busy[0]),      32'd0);
        chk("rst_in_ready",  32'(in_ready[0]),  32'd1);
        chk("rst_out_valid1", 32'(out_valid[1]), 32'd0);
        rst_n = 1'b1;

        // Zero-inversion path
        txn(0, 8'h63, res, lat, lowcnt);
        chk("zero_byte", 32'(res), 32'h00);
        chk("zero_lat",  32'(lat), 32'd3);

        // Directed pairs
        for (int i = 0; i < 4; i++) begin
            txn(0, dir_in[i], res, lat, lowcnt);
            chk("dir_byte", 32'(res),    32'(dir_out[i]));
            chk("dir_lat",  32'(lat),    32'd3);
            chk("dir_low",  32'(lowcnt), 32'd4);
        end

        // Exhaustive, REG_ISO=0
        for (int i = 0; i < 256; i++) begin
            txn(0, 8'(i), res, lat, lowcnt);
            chk("exh0_byte", 32'(res), 32'(inv_tab[i]));
        end

        // Random forward-then-inverse round trip
        for (int i = 0; i < 32; i++) begin
            x = 8'($urandom_range(0, 255));
            txn(0, fwd_tab[x], res, lat, lowcnt);
            chk("rt_byte", 32'(res), 32'(x));
        end

        // Backpressure
        @(negedge clk);
        in_valid[0] = 1'b1; in_byte[0] = 8'hED; out_ready[0] = 1'b0;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_reach_valid", 32'(out_valid[0]), 32'd1);
        for (int c = 0; c < 10; c++) begin
            chk("bp_valid",    32'(out_valid[0]), 32'd1);
            chk("bp_byte",     32'(out_byte[0]),  32'h53);
            chk("bp_in_ready", 32'(in_ready[0]),  32'd0);
            in_valid[0] = c[0];
            in_byte[0]  = 8'hAA;
            @(negedge clk);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        chk("bp_rel_valid",    32'(out_valid[0]), 32'd0);
        chk("bp_rel_in_ready", 32'(in_ready[0]),  32'd1);
        chk("bp_rel_busy",     32'(busy[0]),      32'd0);
        chk("bp_rel_keep",     32'(out_byte[0]),  32'h53);
        txn(0, 8'h16, res, lat, lowcnt);
        chk("bp_next_byte", 32'(res), 32'hFF);
        chk("bp_next_lat",  32'(lat), 32'd3);

        // Reset during INV
        @(negedge clk);
        in_valid[0] = 1'b1; in_byte[0] = 8'h7C;
        @(posedge clk);
        #1 in_valid[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 32'(busy[0]), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    32'(out_valid[0]), 32'd0);
        chk("mid_rst_byte",     32'(out_byte[0]),  32'h00);
        chk("mid_rst_in_ready", 32'(in_ready[0]),  32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("mid_no_output", 32'(out_valid[0]), 32'd0);
        end
        txn(0, 8'h7C, res, lat, lowcnt);
        chk("mid_next_byte", 32'(res), 32'h01);
        chk("mid_next_lat",  32'(lat), 32'd3);

        // REG_ISO=1 instance
        txn(1, 8'h00, res, lat, lowcnt);
        chk("reg_byte", 32'(res),    32'h52);
        chk("reg_lat",  32'(lat),    32'd4);
        chk("reg_low",  32'(lowcnt), 32'd5);
        for (int i = 0; i < 256; i++) begin
            txn(1, 8'(i), res, lat, lowcnt);
            chk("exh1_byte", 32'(res), 32'(inv_tab[i]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
